sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_pkg.sv | 46 ++++
 rtl/sha256_padder.sv | 138 +++++++++++++
 tb/tb_sha256_padder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared sizes, state type and pad-word helpers for the SHA-256 padder
package sha256_pkg;

    localparam int          SHA256_BLOCK_WORDS = 16;
    localparam logic [31:0] SHA256_PAD_WORD    = 32'h80000000;
    localparam int          SHA256_LEN_WORD_HI = 14;
    localparam int          SHA256_LEN_WORD_LO = 15;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_SEND   = 1'b1
    } PadderState;

    // Out-of-range byte counts are treated as a full word so the length and
    // mask logic never sees a value above four.
    function automatic logic [2:0] sha256_clamp_bytes(input logic [2:0] nbytes);
        return (nbytes > 3'd4) ? 3'd4 : nbytes;
    endfunction

    // Left-justified mask keeping the first nbytes bytes of a big-endian word.
    function automatic logic [31:0] sha256_byte_mask(input logic [2:0] nbytes);
        logic [31:0] mask;
        case (nbytes)
            3'd0:    mask = 32'h00000000;
            3'd1:    mask = 32'hFF000000;
            3'd2:    mask = 32'hFFFF0000;
            3'd3:    mask = 32'hFFFFFF00;
            default: mask = 32'hFFFFFFFF;
        endcase
        return mask;
    endfunction

    // Zero the bytes past nbytes and, on a short final beat, drop the 0x80
    // pad byte into the first unused byte position.
    function automatic logic [31:0] sha256_insert_pad(input logic [31:0] data,
                                                      input logic [2:0]  nbytes,
                                                      input logic        is_last);
        logic [31:0] word;
        word = data & sha256_byte_mask(nbytes);
        if (is_last && (nbytes < 3'd4)) begin
            word = word | (SHA256_PAD_WORD >> {nbytes, 3'b000});
        end
        return word;
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - packs message beats into padded 512-bit SHA-256 chunks
module sha256_padder
    import sha256_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  msg_vld,
    output logic                                  msg_rdy,
    input  logic [31:0]                           msg_data,
    input  logic [2:0]                            msg_bytes,
    input  logic                                  msg_last,
    output logic                                  chunk_vld,
    input  logic                                  chunk_rdy,
    output logic [SHA256_BLOCK_WORDS-1:0][31:0]   chunk_data,
    output logic                                  chunk_last
);

    PadderState                          state_q;
    logic [3:0]                          idx_q;
    logic [63:0]                         len_q;
    logic                                need_extra_q;
    logic                                extra_pad_q;
    logic [SHA256_BLOCK_WORDS-1:0][31:0] buf_q;
    logic                                msg_rdy_q;
    logic                                chunk_vld_q;
    logic                                chunk_last_q;

    logic [2:0]                          nbytes_c;
    logic [31:0]                         beat_word;
    logic [63:0]                         len_next;
    logic                                pad_in_next;
    logic [4:0]                          pad_pos;
    logic                                pad_fits;

    // Per-beat values: masked/padded word, running length including this beat,
    // and the word index the pad byte lands in (16 means "next chunk").
    always_comb begin
        nbytes_c    = sha256_clamp_bytes(msg_bytes);
        beat_word   = sha256_insert_pad(msg_data, nbytes_c, msg_last);
        len_next    = len_q + 64'({nbytes_c, 3'b000});
        pad_in_next = msg_last && (nbytes_c == 3'd4);
        pad_pos     = {1'b0, idx_q} + (pad_in_next ? 5'd1 : 5'd0);
        pad_fits    = pad_pos < 5'(SHA256_LEN_WORD_HI);
    end

    // Accept/send FSM; buffer, length and all handshake outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCEPT;
            idx_q        <= 4'd0;
            len_q        <= 64'd0;
            need_extra_q <= 1'b0;
            extra_pad_q  <= 1'b0;
            buf_q        <= '0;
            msg_rdy_q    <= 1'b1;
            chunk_vld_q  <= 1'b0;
            chunk_last_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (msg_vld) begin
                        buf_q[idx_q] <= beat_word;
                        len_q        <= len_next;
                        if (!msg_last) begin
                            if (idx_q != 4'd15) begin
                                idx_q <= idx_q + 4'd1;
                            end else begin
                                // Chunk filled by data alone; more beats follow.
                                state_q      <= ST_SEND;
                                msg_rdy_q    <= 1'b0;
                                chunk_vld_q  <= 1'b1;
                                chunk_last_q <= 1'b0;
                                need_extra_q <= 1'b0;
                                extra_pad_q  <= 1'b0;
                            end
                        end else begin
                            if (pad_in_next && (idx_q != 4'd15)) begin
                                buf_q[idx_q + 4'd1] <= SHA256_PAD_WORD;
                            end
                            if (pad_fits) begin
                                buf_q[SHA256_LEN_WORD_HI] <= len_next[63:32];
                                buf_q[SHA256_LEN_WORD_LO] <= len_next[31:0];
                                chunk_last_q <= 1'b1;
                                need_extra_q <= 1'b0;
                                extra_pad_q  <= 1'b0;
                            end else begin
                                // Length does not fit; it goes into a trailing chunk,
                                // which also carries the pad word if it spilled over.
                                chunk_last_q <= 1'b0;
                                need_extra_q <= 1'b1;
                                extra_pad_q  <= (pad_pos == 5'd16);
                            end
                            state_q     <= ST_SEND;
                            msg_rdy_q   <= 1'b0;
                            chunk_vld_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (chunk_rdy) begin
                        if (need_extra_q) begin
                            buf_q    <= '0;
                            buf_q[0] <= extra_pad_q ? SHA256_PAD_WORD : 32'h0;
                            buf_q[SHA256_LEN_WORD_HI] <= len_q[63:32];
                            buf_q[SHA256_LEN_WORD_LO] <= len_q[31:0];
                            chunk_last_q <= 1'b1;
                            need_extra_q <= 1'b0;
                            extra_pad_q  <= 1'b0;
                        end else begin
                            // Buffer is cleared so unwritten words of the next
                            // chunk read as zero padding.
                            if (chunk_last_q) begin
                                len_q <= 64'd0;
                            end
                            idx_q        <= 4'd0;
                            buf_q        <= '0;
                            state_q      <= ST_ACCEPT;
                            msg_rdy_q    <= 1'b1;
                            chunk_vld_q  <= 1'b0;
                            chunk_last_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_ACCEPT;
                    msg_rdy_q   <= 1'b1;
                    chunk_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign msg_rdy    = msg_rdy_q;
    assign chunk_vld  = chunk_vld_q;
    assign chunk_last = chunk_last_q;
    assign chunk_data = buf_q;

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - randomized self-checking bench for sha256_padder
module tb_sha256_padder;
    import sha256_pkg::*;

    logic                                clk = 1'b0;
    logic                                rst;
    logic                                msg_vld;
    logic                                msg_rdy;
    logic [31:0]                         msg_data;
    logic [2:0]                          msg_bytes;
    logic                                msg_last;
    logic                                chunk_vld;
    logic                                chunk_rdy;
    logic [SHA256_BLOCK_WORDS-1:0][31:0] chunk_data;
    logic                                chunk_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  msg_q[$];
    logic [31:0] exp_w[$];
    int          n_chunks;

    sha256_padder dut (
        .clk        (clk),
        .rst        (rst),
        .msg_vld    (msg_vld),
        .msg_rdy    (msg_rdy),
        .msg_data   (msg_data),
        .msg_bytes  (msg_bytes),
        .msg_last   (msg_last),
        .chunk_vld  (chunk_vld),
        .chunk_rdy  (chunk_rdy),
        .chunk_data (chunk_data),
        .chunk_last (chunk_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Standard SHA-256 padding on a byte stream, then split into 32-bit words.
    task automatic build_model();
        logic [7:0]  p[$];
        logic [63:0] bit_len;
        p = msg_q;
        bit_len = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int b = 7; b >= 0; b--) p.push_back(bit_len[8*b +: 8]);
        exp_w.delete();
        for (int i = 0; i < p.size(); i += 4) exp_w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
        n_chunks = p.size() / 64;
    endtask

    task automatic drive_msg(input bit zero_tail, input int max_gap);
        int n, full, rem, wait_c;
        logic [31:0] bd[$];
        int          bb[$];
        bit          bl[$];
        logic [31:0] w;
        n = msg_q.size();
        full = n / 4;
        rem = n % 4;
        if (rem == 0 && n > 0 && !zero_tail) begin
            for (int i = 0; i < full; i++) begin
                bd.push_back({msg_q[4*i], msg_q[4*i+1], msg_q[4*i+2], msg_q[4*i+3]});
                bb.push_back(4);
                bl.push_back(i == full - 1);
            end
        end else begin
            for (int i = 0; i < full; i++) begin
                bd.push_back({msg_q[4*i], msg_q[4*i+1], msg_q[4*i+2], msg_q[4*i+3]});
                bb.push_back(4);
                bl.push_back(1'b0);
            end
            w = $urandom;
            for (int b = 0; b < rem; b++) w[31-8*b -: 8] = msg_q[4*full+b];
            bd.push_back(w);
            bb.push_back(rem);
            bl.push_back(1'b1);
        end
        for (int i = 0; i < bd.size(); i++) begin
            msg_vld = 1'b0;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            msg_vld   = 1'b1;
            msg_data  = bd[i];
            msg_bytes = 3'(bb[i]);
            msg_last  = bl[i];
            wait_c = 0;
            while (!msg_rdy && wait_c < 500) begin
                @(negedge clk);
                wait_c++;
            end
            if (!msg_rdy) begin
                check_eq("msg_rdy_wait", 64'(msg_rdy), 64'd1);
                break;
            end
            @(negedge clk);
        end
        msg_vld  = 1'b0;
        msg_last = 1'b0;
    endtask

    task automatic collect();
        int got, cyc;
        got = 0;
        cyc = 0;
        while (got < n_chunks && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (chunk_vld) begin
                for (int w = 0; w < 16; w++)
                    check_eq($sformatf("c%0d_w%0d", got, w), 64'(chunk_data[w]), 64'(exp_w[got*16+w]));
                check_eq($sformatf("c%0d_last", got), 64'(chunk_last), 64'(got == n_chunks - 1));
                check_eq("msg_rdy_in_send", 64'(msg_rdy), 64'd0);
                if ($urandom_range(0, 2) != 0) begin
                    chunk_rdy = 1'b1;
                    got++;
                end else begin
                    chunk_rdy = 1'b0;
                end
            end else begin
                chunk_rdy = 1'($urandom_range(0, 1));
            end
        end
        check_eq("chunk_count", 64'(got), 64'(n_chunks));
        @(negedge clk);
        chunk_rdy = 1'b0;
        check_eq("vld_after_msg", 64'(chunk_vld), 64'd0);
    endtask

    task automatic run_current(input bit zero_tail, input int max_gap);
        build_model();
        fork
            drive_msg(zero_tail, max_gap);
            collect();
        join
    endtask

    task automatic load_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    task automatic load_random(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        rst       = 1'b1;
        msg_vld   = 1'b0;
        msg_data  = '0;
        msg_bytes = '0;
        msg_last  = 1'b0;
        chunk_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_chunk_vld", 64'(chunk_vld), 64'd0);
        check_eq("rst_msg_rdy", 64'(msg_rdy), 64'd1);
        check_eq("rst_chunk_last", 64'(chunk_last), 64'd0);
        check_eq("rst_chunk_w0", 64'(chunk_data[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed corner lengths: abc, empty, 55/56/57/60/63/64 bytes.
        load_abc();
        run_current(1'b0, 0);
        load_random(0);
        run_current(1'b0, 0);
        load_random(56);
        run_current(1'b0, 1);
        load_random(64);
        run_current(1'b0, 1);
        load_random(64);
        run_current(1'b1, 1);
        foreach (msg_q[i]) msg_q[i] = msg_q[i];
        load_random(55);
        run_current(1'b0, 0);
        load_random(57);
        run_current(1'b0, 0);
        load_random(60);
        run_current(1'b1, 0);
        load_random(63);
        run_current(1'b0, 2);

        // Backpressure then reset while the chunk is still offered.
        load_abc();
        build_model();
        drive_msg(1'b0, 0);
        check_eq("bp_latency_vld", 64'(chunk_vld), 64'd1);
        repeat (5) begin
            check_eq("bp_w0", 64'(chunk_data[0]), 64'(exp_w[0]));
            check_eq("bp_w15", 64'(chunk_data[15]), 64'(exp_w[15]));
            check_eq("bp_msg_rdy", 64'(msg_rdy), 64'd0);
            check_eq("bp_vld", 64'(chunk_vld), 64'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("send_rst_vld", 64'(chunk_vld), 64'd0);
        check_eq("send_rst_rdy", 64'(msg_rdy), 64'd1);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("post_rst_idle", 64'(chunk_vld), 64'd0);
        end
        load_abc();
        run_current(1'b0, 0);

        // Reset in the middle of filling a chunk.
        msg_vld   = 1'b1;
        msg_data  = 32'hDEADBEEF;
        msg_bytes = 3'd4;
        msg_last  = 1'b0;
        repeat (5) @(negedge clk);
        msg_vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_vld", 64'(chunk_vld), 64'd0);
        load_abc();
        run_current(1'b0, 0);

        // Random lengths, tails and gaps.
        for (int t = 0; t < 30; t++) begin
            load_random($urandom_range(0, 140));
            run_current(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
